// File: rtl/text_pkg.sv
// text_pkg: shared state encoding, colour constants and attribute layout for the text pixel engine
package text_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TXT,
        S_FONT,
        S_GLYPH,
        S_SHIFT
    } state_e;

    localparam logic [15:0] AMBER = 16'hFDE0;
    localparam logic [15:0] BLACK = 16'h0000;

    localparam int CODE_LSB = 0;
    localparam int FG_LSB   = 8;
    localparam int BG_LSB   = 12;

    localparam logic [15:0] PALETTE [16] = '{
        16'h0000, 16'h0015, 16'h0540, 16'h0555,
        16'hA800, 16'hA815, 16'hA2A0, 16'hAD55,
        16'h52AA, 16'h52BF, 16'h57EA, 16'h57FF,
        16'hFAAA, 16'hFABF, 16'hFFEA, 16'hFFFF
    };

endpackage

// File: rtl/cell_counters.sv
// cell_counters: pixel/column/scanline/row walk over the text grid with raster edge flags
module cell_counters #(
    parameter  int COLS   = 80,
    parameter  int ROWS   = 30,
    parameter  int CHAR_W = 8,
    parameter  int CHAR_H = 16,
    localparam int PW     = $clog2(CHAR_W),
    localparam int CW     = $clog2(COLS),
    localparam int SW     = $clog2(CHAR_H),
    localparam int RW     = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [CW-1:0] col_o,
    output logic [SW-1:0] scan_o,
    output logic [RW-1:0] row_o,
    output logic          first_o,
    output logic          last_px_o,
    output logic          eol_o,
    output logic          eof_o
);

    logic [PW-1:0] px_q, px_d;
    logic [CW-1:0] col_q, col_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [RW-1:0] row_q, row_d;
    logic last_col, last_scan, last_row, step_col, step_scan, step_row;

    assign last_px_o = px_q == PW'(CHAR_W - 1);
    assign last_col  = col_q == CW'(COLS - 1);
    assign last_scan = scan_q == SW'(CHAR_H - 1);
    assign last_row  = row_q == RW'(ROWS - 1);
    assign step_col  = adv_i & last_px_o;
    assign step_scan = step_col & last_col;
    assign step_row  = step_scan & last_scan;

    // Each counter wraps to zero and carries into the next one up; clear parks the walk at cell (0,0)
    always_comb begin
        px_d   = clr_i ? '0 : adv_i ? (last_px_o ? '0 : px_q + 1'b1) : px_q;
        col_d  = clr_i ? '0 : step_col ? (last_col ? '0 : col_q + 1'b1) : col_q;
        scan_d = clr_i ? '0 : step_scan ? (last_scan ? '0 : scan_q + 1'b1) : scan_q;
        row_d  = clr_i ? '0 : step_row ? (last_row ? '0 : row_q + 1'b1) : row_q;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            px_q   <= '0;
            col_q  <= '0;
            scan_q <= '0;
            row_q  <= '0;
        end else begin
            px_q   <= px_d;
            col_q  <= col_d;
            scan_q <= scan_d;
            row_q  <= row_d;
        end
    end

    assign col_o   = col_q;
    assign scan_o  = scan_q;
    assign row_o   = row_q;
    assign first_o = ~|{px_q, col_q, scan_q, row_q};
    assign eol_o   = last_px_o & last_col;
    assign eof_o   = eol_o & last_scan & last_row;

endmodule

// File: rtl/text_pixel_pipeline.sv
// text_pixel_pipeline: walks the text grid, fetches code/glyph rows and streams RGB565 pixels in raster order
module text_pixel_pipeline
    import text_pkg::*;
#(
    parameter  int COLS         = 80,
    parameter  int ROWS         = 30,
    parameter  int CHAR_W       = 8,
    parameter  int CHAR_H       = 16,
    parameter  int BLINK_FRAMES = 30,
    localparam int CW           = $clog2(COLS),
    localparam int RW           = $clog2(ROWS),
    localparam int SW           = $clog2(CHAR_H),
    localparam int AW           = $clog2(COLS * ROWS),
    localparam int BW           = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              cursor_en,
    input  logic [CW-1:0]     cursor_col,
    input  logic [RW-1:0]     cursor_row,
    output logic [AW-1:0]     txt_addr,
    input  logic [15:0]       txt_data,
    output logic [8+SW-1:0]   font_addr,
    input  logic [CHAR_W-1:0] font_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [15:0]       pix_data,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy
);

    state_e state_q, state_d;
    logic              mode_q, cur_en_q, blink_on_q;
    logic [CW-1:0]     cur_col_q, col;
    logic [RW-1:0]     cur_row_q, row;
    logic [SW-1:0]     scan;
    logic [15:0]       attr_q, fg, bg;
    logic [CHAR_W-1:0] shift_q;
    logic [BW-1:0]     blink_cnt_q;
    logic fire, start, first, last_px, eol, eof, inv, blink_wrap;

    cell_counters #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == S_IDLE),
        .adv_i     (fire),
        .col_o     (col),
        .scan_o    (scan),
        .row_o     (row),
        .first_o   (first),
        .last_px_o (last_px),
        .eol_o     (eol),
        .eof_o     (eof)
    );

    assign pix_valid  = state_q == S_SHIFT;
    assign busy       = state_q != S_IDLE;
    assign fire       = pix_valid & pix_ready;
    assign start      = en & (state_q == S_IDLE | (fire & eof));
    assign blink_wrap = blink_cnt_q == BW'(BLINK_FRAMES - 1);

    // The font fetch is issued in FONT straight from the RAM output so a cell costs only three fetch cycles
    assign txt_addr  = AW'(row * COLS + col);
    assign font_addr = {state_q == S_FONT ? txt_data[CODE_LSB+:8] : attr_q[CODE_LSB+:8], scan};

    // Colour and cursor come only from registered state, so nothing on the inputs reaches pix_data
    assign fg  = mode_q ? PALETTE[attr_q[FG_LSB+:4]] : AMBER;
    assign bg  = mode_q ? PALETTE[attr_q[BG_LSB+:4]] : BLACK;
    assign inv = cur_en_q & blink_on_q & row == cur_row_q & col == cur_col_q & scan >= SW'(CHAR_H - 2);
    assign pix_data = pix_valid ? ((shift_q[CHAR_W-1] ^ inv) ? fg : bg) : BLACK;
    assign pix_sof  = pix_valid & first;
    assign pix_eol  = pix_valid & eol;
    assign pix_eof  = pix_valid & eof;

    // Next state: fetch three cycles per cell, then shift out one pixel per handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = en ? S_TXT : S_IDLE;
            S_TXT:   state_d = S_FONT;
            S_FONT:  state_d = S_GLYPH;
            S_GLYPH: state_d = S_SHIFT;
            S_SHIFT: state_d = !(fire && last_px) ? S_SHIFT : (eof && !en) ? S_IDLE : S_TXT;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    // Frame-stable controls, fetched cell data, glyph shifter and blink phase
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= 1'b0;
            cur_en_q    <= 1'b0;
            cur_col_q   <= '0;
            cur_row_q   <= '0;
            attr_q      <= '0;
            shift_q     <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            if (start) begin
                mode_q    <= mode;
                cur_en_q  <= cursor_en;
                cur_col_q <= cursor_col;
                cur_row_q <= cursor_row;
            end
            if (state_q == S_FONT) attr_q <= txt_data;
            if (state_q == S_GLYPH) shift_q <= font_data;
            else if (fire) shift_q <= shift_q << 1;
            if (fire && eof) begin
                blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + 1'b1;
                if (blink_wrap) blink_on_q <= ~blink_on_q;
            end
        end
    end

endmodule

// File: tb/tb_text_pixel_pipeline.sv
// tb_text_pixel_pipeline: randomized stream checks against a raster-order reference model
module tb_text_pixel_pipeline;
    import text_pkg::*;

    localparam int COLS = 4, ROWS = 2, CHAR_W = 8, CHAR_H = 4, BLINK = 2;
    localparam int FP = COLS * ROWS * CHAR_H * CHAR_W;

    logic        clk, rst, en, mode, cursor_en, pix_ready;
    logic [1:0]  cursor_col;
    logic [0:0]  cursor_row;
    logic [2:0]  txt_addr;
    logic [15:0] txt_data;
    logic [9:0]  font_addr;
    logic [7:0]  font_data;
    logic        pix_valid, pix_sof, pix_eol, pix_eof, busy;
    logic [15:0] pix_data;

    logic [15:0] txt_mem [COLS*ROWS];
    logic [7:0]  font_mem [256*CHAR_H];
    logic [18:0] q [$];
    logic [15:0] g_first [8];
    logic        f_md [8], f_ce [8];
    int          f_cc [8], f_cr [8];
    int n_tests, n_fail, fcnt;
    int g_pix, g_sof, g_eol, g_eof, g_lat, g_c0, g_c8, g_amber, g_txt0, g_font0;

    text_pixel_pipeline #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .BLINK_FRAMES(BLINK)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .cursor_en(cursor_en),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .txt_addr(txt_addr), .txt_data(txt_data), .font_addr(font_addr), .font_data(font_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        txt_data  <= txt_mem[txt_addr];
        font_data <= font_mem[font_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1; en = 0; pix_ready = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        fcnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, {pix_valid, pix_sof, pix_eol, pix_eof, busy}, 0);
        check({tag, "_data"}, pix_data, 0);
        check({tag, "_addr"}, {txt_addr, font_addr}, 0);
    endtask

    // Expected raster stream of one frame, straight from the pixel/colour/cursor/blink rules
    task automatic build(input int f, input logic md, input logic ce, input int cc, input int cr);
        logic [15:0] w, fg, bg;
        logic [7:0] g;
        logic inv, b;
        for (int r = 0; r < ROWS; r++)
            for (int s = 0; s < CHAR_H; s++)
                for (int c = 0; c < COLS; c++)
                    for (int p = 0; p < CHAR_W; p++) begin
                        w   = txt_mem[r*COLS+c];
                        g   = font_mem[w[7:0]*CHAR_H+s];
                        b   = g[CHAR_W-1-p];
                        fg  = md ? PALETTE[w[11:8]] : 16'hFDE0;
                        bg  = md ? PALETTE[w[15:12]] : 16'h0000;
                        inv = ce && ((f / BLINK) % 2 == 0) && r == cr && c == cc && s >= CHAR_H - 2;
                        q.push_back({r == 0 && s == 0 && c == 0 && p == 0,
                                     c == COLS-1 && p == CHAR_W-1,
                                     c == COLS-1 && p == CHAR_W-1 && r == ROWS-1 && s == CHAR_H-1,
                                     (b ^ inv) ? fg : bg});
                    end
    endtask

    task automatic drive_ctl(input int k, input int nfr);
        if (k < nfr) begin
            mode = f_md[k]; cursor_en = f_ce[k]; cursor_col = 2'(f_cc[k]); cursor_row = 1'(f_cr[k]);
        end else begin
            mode = 1'($urandom); cursor_en = 1'($urandom); cursor_col = 2'($urandom); cursor_row = 1'($urandom);
        end
    endtask

    // Runs nfr back-to-back frames from IDLE; controls for frame k+1 are driven during frame k, en drops in the last
    task automatic run_frames(input int nfr, input int rdy);
        int cyc, idx, total, k;
        q.delete();
        for (int i = 0; i < nfr; i++) build(fcnt + i, f_md[i], f_ce[i], f_cc[i], f_cr[i]);
        total = nfr * FP; idx = 0; cyc = 0;
        g_pix = 0; g_sof = 0; g_eol = 0; g_eof = 0; g_lat = -1; g_amber = 0; g_c0 = 0; g_c8 = 0;
        drive_ctl(0, nfr);
        en = 1;
        while (idx < total && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) g_txt0 = txt_addr;
            if (cyc == 2) g_font0 = font_addr;
            pix_ready = $urandom_range(99) < rdy;
            if (pix_valid) begin
                if (g_lat < 0) g_lat = cyc;
                check("pix", {pix_sof, pix_eol, pix_eof, pix_data}, q[0]);
                if (pix_ready) begin
                    if (idx < 8) g_first[idx] = pix_data;
                    if (idx == 0) g_c0 = cyc;
                    if (idx == 8) g_c8 = cyc;
                    g_pix++; g_sof += pix_sof; g_eol += pix_eol; g_eof += pix_eof;
                    g_amber += (pix_data == 16'hFDE0);
                    void'(q.pop_front());
                    idx++;
                    if (idx % FP == 1) begin
                        k = idx / FP + 1;
                        drive_ctl(k, nfr);
                        if (k == nfr) en = 0;
                    end
                end
            end
        end
        check("frames_done", idx, total);
        pix_ready = 1;
        cyc = 0;
        while (busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("stay_idle", {busy, pix_valid}, 0);
        fcnt += nfr;
    endtask

    task automatic fill_random();
        foreach (txt_mem[i]) txt_mem[i] = 16'($urandom);
        foreach (font_mem[i]) font_mem[i] = 8'($urandom);
    endtask

    task automatic set_all(input logic md, input logic ce, input int cc, input int cr);
        for (int i = 0; i < 8; i++) begin
            f_md[i] = md; f_ce[i] = ce; f_cc[i] = cc; f_cr[i] = cr;
        end
    endtask

    initial begin
        int idx, cyc;
        n_tests = 0; n_fail = 0;
        rst = 1; en = 0; mode = 0; cursor_en = 0; cursor_col = 0; cursor_row = 0; pix_ready = 1;
        fill_random();
        reset_dut();
        check_reset_outputs("reset");

        // Mono amber, glyph A5 everywhere, single frame with en dropped mid-frame
        foreach (font_mem[i]) font_mem[i] = 8'hA5;
        set_all(0, 0, 0, 0);
        run_frames(1, 100);
        check("a_pix0", g_first[0], 16'hFDE0);
        check("a_pix1", g_first[1], 16'h0000);
        check("a_count", g_pix, 256);
        check("a_sof", g_sof, 1);
        check("a_eol", g_eol, 8);
        check("a_eof", g_eof, 1);
        check("a_latency", g_lat, 4);
        check("a_cell_cycles", g_c8 - g_c0, 11);

        // 16-colour attributes on cell 0
        fill_random();
        txt_mem[0] = 16'h2141;
        for (int s = 0; s < CHAR_H; s++) font_mem[8'h41*CHAR_H+s] = 8'hF0;
        set_all(1, 0, 0, 0);
        run_frames(1, 100);
        check("b_txt_addr", g_txt0, 0);
        check("b_font_addr", g_font0, {8'h41, 2'b00});
        check("b_pix0", g_first[0], PALETTE[1]);
        check("b_pix3", g_first[3], PALETTE[1]);
        check("b_pix4", g_first[4], PALETTE[2]);
        check("b_pix7", g_first[7], PALETTE[2]);

        // Random content, random per-frame controls, 50% backpressure
        fill_random();
        for (int i = 0; i < 8; i++) begin
            f_md[i] = 1'($urandom); f_ce[i] = 1'($urandom);
            f_cc[i] = $urandom_range(COLS-1); f_cr[i] = $urandom_range(ROWS-1);
        end
        run_frames(3, 50);
        check("c_sof", g_sof, 3);
        check("c_eof", g_eof, 3);

        // Blinking cursor at (1,0) over a blank font across two blink phases
        reset_dut();
        fill_random();
        foreach (font_mem[i]) font_mem[i] = 8'h00;
        set_all(0, 1, 1, 0);
        run_frames(4, 100);
        check("d_cursor_amber", g_amber, 32);

        // Reset in the middle of cell 3, then a clean frame
        reset_dut();
        fill_random();
        set_all(1, 1, 2, 1);
        mode = 1; en = 1; pix_ready = 1;
        idx = 0; cyc = 0;
        while (idx < 27 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (pix_valid) idx++;
        end
        check("e_reach", idx, 27);
        rst = 1; en = 0;
        @(negedge clk);
        check_reset_outputs("e_reset");
        rst = 0;
        fcnt = 0;
        run_frames(1, 70);
        check("e_txt_addr", g_txt0, 0);
        check("e_sof", g_sof, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
